sr_lsu: RTL and testbench
=========================

# sr_lsu

Load/store unit between the `sr_cpu` data-memory port and a synchronous single-port 32-bit word RAM. It converts byte, half and word accesses into word-RAM beats with byte enables. Misaligned accesses that cross a word boundary are split into two beats. It performs load alignment and sign/zero extension, and asserts `stall` so the CPU holds its PC while an access is incomplete.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width (RAM depth 2^ADDR_W words)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  CPU presents a memory instruction this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [ADDR_W+1:2] = word, [1:0] = offset
- req_wdata  in  32  store data, right-justified
- req_byte / req_half / req_word  in  1 each  access size; priority byte > half > word; none set = word
- req_sign  in  1  1 = sign-extend load, 0 = zero-extend
- stall  out  1  CPU must hold PC and request stable while high
- resp_valid  out  1  rdata valid this cycle (loads only)
- rdata  out  32  extended load result; 0 when resp_valid = 0
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  RAM write (qualified by mem_en)
- mem_addr  out  ADDR_W  RAM word address
- mem_be  out  4  byte-lane write enables, lane i = bits [8i+7:8i]
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after a read beat

## Operation
- Size in bytes is N = 1/2/4. Offset is o = req_addr[1:0]. An access crosses when o + N > 4: half at o=3, or word at o≠0. Bytes never cross.
- Word A = req_addr[ADDR_W+1:2]. Second word is A+1 modulo 2^ADDR_W, wrapping to 0.
- Lane mask is m8 = ((1<<N)-1) << o (8 bits). Store data is d64 = zero-ext(req_wdata[8N-1:0]) << 8o.
  - Beat to A: be = m8[3:0], wdata = d64[31:0].
  - Beat to A+1: be = m8[7:4], wdata = d64[63:32].
- Load: lo = word A, hi = word A+1 (don't-care if not crossing). x = ({hi,lo} >> 8o)[8N-1:0]. Extend x to 32 bits per req_sign.
- FSM states: IDLE, LD_WAIT, LD_HI, ST_HI.
  - IDLE: mem port is driven combinationally from the request (first beat, word A).
    - No req_valid: mem_en = 0, stall = 0.
    - Aligned store: write A, stall = 0, stay in IDLE.
    - Crossing store: write A, stall = 1, capture request, go to ST_HI.
    - Aligned load: read A, stall = 1, go to LD_WAIT.
    - Crossing load: read A, stall = 1, go to LD_HI.
  - LD_HI: latch mem_rdata as lo, read A+1, stall = 1, go to LD_WAIT.
  - LD_WAIT: mem_en = 0, resp_valid = 1, rdata from mem_rdata (and the latched lo if crossing), stall = 0, go to IDLE.
  - ST_HI: write A+1 with the captured be/wdata, stall = 0, go to IDLE.
- Request inputs are ignored outside IDLE. Last-cycle states (LD_WAIT, ST_HI) never re-issue the still-present request.
- All request fields needed in later states are registered at acceptance.

## Timing
- Reset (rst = 1 at a rising edge):
  - Next cycle: state = IDLE, stall = 0, resp_valid = 0, rdata = 0, mem_en = 0, mem_we = 0.
  - While rst is high, mem_en and stall are forced to 0 regardless of req_valid.
  - Reset mid-access abandons the access. A pending ST_HI beat is never written, and no resp_valid is produced.
- Latency, where T = request cycle:
  - Aligned store: 1 cycle, never stalls.
  - Crossing store: 2 cycles, stall high in T only.
  - Aligned load: resp_valid in T+1, stall high in T.
  - Crossing load: resp_valid in T+2, stall high in T and T+1.
- Back-to-back: a new request is accepted in the cycle after the final cycle of the previous access. An aligned store can be accepted every cycle.
- Load/store to the same word: the RAM returns old data for a read issued in the same cycle as a write. The ordering above never overlaps them.

## Test plan
- Reset: assert rst with req_valid = 1 and a load → stall = 0, mem_en = 0 during reset; resp_valid = 0 and rdata = 0 the cycle after release.
- Aligned byte store, then load: store 0xA5 to 0x103, then signed byte load at 0x103:
  - Store: mem_addr = 0x40, be = 4'b1000, wdata = 0xA5000000, no stall.
  - Load: resp_valid at T+1, rdata = 0xFFFFFFA5. The unsigned load gives 0x000000A5.
- Crossing word store: store 0x11223344 to 0x002 → beats:
  - T: addr 0, be = 4'b1100, wdata = 0x33440000.
  - T+1: addr 1, be = 4'b0011, wdata = 0x00001122.
  - stall high in T only.
- Crossing signed half load at 0x007 with RAM[1] = 0x80xxxxxx and RAM[2] = 0xxxxxxxF0 → reads addr 1 then 2, stall high for 2 cycles, rdata = 0xFFFFF080 at T+2.
- Wrap-around: word load at byte address 4·(2^ADDR_W−1)+1 → second beat mem_addr = 0, result assembled from the last word and word 0.
- Reset in LD_HI of a crossing load, and separately in ST_HI of a crossing store → no resp_valid, no second-beat write (mem_en = 0), FSM back in IDLE and accepting a request 1 cycle after reset release.

Source files
------------

// File: rtl/sr_lsu.sv
// sr_lsu: load/store unit between the sr_cpu data port and a single-port 32-bit word RAM.
// Word-crossing accesses become two RAM beats; loads are realigned and sign/zero extended.
module sr_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_byte,
  input  logic              req_half,
  input  logic              req_word,
  input  logic              req_sign,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, LD_WAIT, LD_HI, ST_HI} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e            state, nextState;
  size_e             reqSize, sizeReg;
  logic [1:0]        reqOff, offReg;
  logic [2:0]        reqBytes;
  logic [3:0]        laneMask;
  logic [31:0]       wdataMasked;
  logic [7:0]        m8;
  logic [63:0]       d64;
  logic              reqCross, crossReg, signReg;
  logic [ADDR_W-1:0] reqWordAddr, hiWordReg;
  logic [3:0]        hiBeReg;
  logic [31:0]       hiWdataReg, loReg;
  logic [63:0]       loadPair;
  logic [31:0]       loadWord, loadResult;
  logic              unusedIn;

  // Upper address bits select nothing in the RAM; req_word only matters when no other size is set.
  assign unusedIn    = ^{req_addr[31:ADDR_W+2], req_word};
  assign reqOff      = req_addr[1:0];
  assign reqWordAddr = req_addr[ADDR_W+1:2];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    reqSize     = SZ_WORD;
    reqBytes    = 3'd4;
    laneMask    = 4'b1111;
    wdataMasked = req_wdata;
    if (req_byte) begin
      reqSize     = SZ_BYTE;
      reqBytes    = 3'd1;
      laneMask    = 4'b0001;
      wdataMasked = {24'h0, req_wdata[7:0]};
    end else if (req_half) begin
      reqSize     = SZ_HALF;
      reqBytes    = 3'd2;
      laneMask    = 4'b0011;
      wdataMasked = {16'h0, req_wdata[15:0]};
    end
  end

  assign reqCross = ({1'b0, reqOff} + reqBytes) > 3'd4;
  assign m8       = {4'b0000, laneMask} << reqOff;
  assign d64      = {32'h0, wdataMasked} << {reqOff, 3'b000};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sizeReg    <= SZ_WORD;
      offReg     <= 2'b00;
      signReg    <= 1'b0;
      crossReg   <= 1'b0;
      hiWordReg  <= '0;
      hiBeReg    <= 4'b0000;
      hiWdataReg <= 32'h0;
      loReg      <= 32'h0;
    end else begin
      if (state == IDLE && req_valid) begin
        sizeReg    <= reqSize;
        offReg     <= reqOff;
        signReg    <= req_sign;
        crossReg   <= reqCross;
        hiWordReg  <= reqWordAddr + ADDR_W'(1);
        hiBeReg    <= m8[7:4];
        hiWdataReg <= d64[63:32];
      end
      if (state == LD_HI) loReg <= mem_rdata;
    end
  end

  // For an aligned load both halves of the pair are the single word just read.
  assign loadPair = {mem_rdata, crossReg ? loReg : mem_rdata};
  assign loadWord = 32'(loadPair >> {offReg, 3'b000});

  always_comb begin
    case (sizeReg)
      SZ_BYTE: loadResult = {{24{signReg & loadWord[7]}}, loadWord[7:0]};
      SZ_HALF: loadResult = {{16{signReg & loadWord[15]}}, loadWord[15:0]};
      default: loadResult = loadWord;
    endcase
  end

  always_comb begin
    nextState  = state;
    stall      = 1'b0;
    resp_valid = 1'b0;
    rdata      = 32'h0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = reqWordAddr;
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          mem_en    = 1'b1;
          mem_we    = req_we;
          mem_be    = m8[3:0];
          mem_wdata = d64[31:0];
          if (req_we) begin
            if (reqCross) begin
              stall     = 1'b1;
              nextState = ST_HI;
            end
          end else begin
            stall     = 1'b1;
            nextState = reqCross ? LD_HI : LD_WAIT;
          end
        end
      end
      LD_HI: begin
        mem_en    = 1'b1;
        mem_addr  = hiWordReg;
        stall     = 1'b1;
        nextState = LD_WAIT;
      end
      LD_WAIT: begin
        resp_valid = 1'b1;
        rdata      = loadResult;
        nextState  = IDLE;
      end
      ST_HI: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = hiWordReg;
        mem_be    = hiBeReg;
        mem_wdata = hiWdataReg;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Reset abandons whatever is in flight, including a pending second store beat.
    if (rst) begin
      stall      = 1'b0;
      resp_valid = 1'b0;
      rdata      = 32'h0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      nextState  = IDLE;
    end
  end
endmodule

// File: tb/tb_sr_lsu.sv
// Self-checking bench for sr_lsu: behavioral word RAM, byte-level reference memory,
// and a queue of expected load results popped whenever resp_valid is seen.
module tb_sr_lsu;
  localparam int ADDR_W = 10;
  localparam int NBYTES = 4 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_we, req_byte, req_half, req_word, req_sign;
  logic [31:0]       req_addr, req_wdata;
  logic              stall, resp_valid, mem_en, mem_we;
  logic [31:0]       rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expQ[$];
  logic [7:0]  refBytes [0:NBYTES-1];
  logic [31:0] ram [0:(1<<ADDR_W)-1];

  sr_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte(req_byte), .req_half(req_half), .req_word(req_word), .req_sign(req_sign),
    .stall(stall), .resp_valid(resp_valid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // sz: 0 byte, 1 half, 2 word, 3 all flags set (byte wins), 4 no flag (word)
  function automatic int szBytes(input int sz);
    if (sz == 0 || sz == 3) return 1;
    if (sz == 1) return 2;
    return 4;
  endfunction

  function automatic int byteIdx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) & 32'(NBYTES - 1));
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input int n, input logic sg);
    logic [31:0] x;
    x = 32'h0;
    for (int i = 0; i < n; i++) x[8*i +: 8] = refBytes[byteIdx(a, i)];
    if (sg && n == 1) x = {{24{x[7]}}, x[7:0]};
    if (sg && n == 2) x = {{16{x[15]}}, x[15:0]};
    return x;
  endfunction

  task automatic refStore(input logic [31:0] a, input logic [31:0] wd, input int n);
    for (int i = 0; i < n; i++) refBytes[byteIdx(a, i)] = wd[8*i +: 8];
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input int sz, input logic sg);
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_sign = sg;
    req_byte  = (sz == 0 || sz == 3);
    req_half  = (sz == 1 || sz == 3);
    req_word  = (sz == 2 || sz == 3);
  endtask

  task automatic start(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input int sz, input logic sg, input logic [31:0] expVal);
    drive(1'b1, we, a, wd, sz, sg);
    if (we) refStore(a, wd, szBytes(sz));
    else    expQ.push_back(expVal);
  endtask

  task automatic sampleResp();
    logic [31:0] e;
    if (resp_valid === 1'b1) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: rdata=%h with no load outstanding", rdata);
      end else begin
        e = expQ.pop_front();
        if (rdata !== e) begin
          miscompares++;
          $display("FAIL resp_rdata: got %h, want %h", rdata, e);
        end
      end
    end else if (resp_valid !== 1'b0 || rdata !== 32'h0) begin
      vectors++; miscompares++;
      $display("FAIL resp_idle: resp_valid=%b rdata=%h, want 0/00000000", resp_valid, rdata);
    end
  endtask

  // Holds the request until the first cycle with stall low; bounded by a cycle budget.
  task automatic complete(output int stallC, output int respAt,
                          output logic en0, output logic [ADDR_W-1:0] addr0);
    int n;
    bit done;
    stallC = 0; respAt = -1; n = 0; done = 0; en0 = 1'b0; addr0 = '0;
    while (!done) begin
      @(negedge clk);
      if (n == 0) begin en0 = mem_en; addr0 = mem_addr; end
      if (resp_valid === 1'b1) respAt = n;
      sampleResp();
      if (stall === 1'b1) stallC++;
      else done = 1;
      n++;
      if (!done && n >= 8) begin
        vectors++; miscompares++;
        $display("FAIL stall_timeout: stall still high after %0d cycles", n);
        done = 1;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input int sz,
                       input logic sg, input logic [31:0] expVal, output int stallC, output int respAt);
    logic en0;
    logic [ADDR_W-1:0] addr0;
    @(posedge clk); #1;
    start(we, a, wd, sz, sg, expVal);
    complete(stallC, respAt, en0, addr0);
    vectors++;
    if (en0 !== 1'b1 || addr0 !== a[ADDR_W+1:2]) begin
      miscompares++;
      $display("FAIL first_beat: mem_en=%b addr=%h, want 1/%h", en0, addr0, a[ADDR_W+1:2]);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (n) begin @(negedge clk); sampleResp(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h104, 32'h0, 2, 1'b0);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (stall !== 1'b0 || mem_en !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: stall=%b mem_en=%b, want 0/0", stall, mem_en);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: resp_valid=%b rdata=%h stall=%b mem_en=%b mem_we=%b, want all 0",
               resp_valid, rdata, stall, mem_en, mem_we);
    end
  endtask

  task automatic test_byte_store_load();
    int sc, ra;
    @(posedge clk); #1;
    start(1'b1, 32'h103, 32'h123456A5, 0, 1'b0, 32'h0);
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h040 || mem_be !== 4'b1000 ||
        mem_wdata !== 32'hA500_0000 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_store_beat: en=%b we=%b addr=%h be=%b wdata=%h stall=%b, want 1/1/040/1000/a5000000/0",
               mem_en, mem_we, mem_addr, mem_be, mem_wdata, stall);
    end
    issue(1'b0, 32'h103, 32'h0, 0, 1'b1, 32'hFFFF_FFA5, sc, ra);
    vectors++;
    if (sc !== 1 || ra !== 1) begin
      miscompares++;
      $display("FAIL byte_load_timing: stall_cycles=%0d resp_at=%0d, want 1/1", sc, ra);
    end
    issue(1'b0, 32'h103, 32'h0, 0, 1'b0, 32'h0000_00A5, sc, ra);
  endtask

  task automatic test_cross_store();
    int sc, ra;
    issue(1'b1, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, sc, ra);
    issue(1'b1, 32'h4, 32'hCAFE_F00D, 2, 1'b0, 32'h0, sc, ra);
    @(posedge clk); #1;
    start(1'b1, 32'h2, 32'h1122_3344, 2, 1'b0, 32'h0);
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h000 ||
        mem_be !== 4'b1100 || mem_wdata !== 32'h3344_0000) begin
      miscompares++;
      $display("FAIL cross_store_beat0: stall=%b en=%b we=%b addr=%h be=%b wdata=%h, want 1/1/1/000/1100/33440000",
               stall, mem_en, mem_we, mem_addr, mem_be, mem_wdata);
    end
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h001 ||
        mem_be !== 4'b0011 || mem_wdata !== 32'h0000_1122) begin
      miscompares++;
      $display("FAIL cross_store_beat1: stall=%b en=%b we=%b addr=%h be=%b wdata=%h, want 0/1/1/001/0011/00001122",
               stall, mem_en, mem_we, mem_addr, mem_be, mem_wdata);
    end
    issue(1'b0, 32'h0, 32'h0, 2, 1'b0, 32'h3344_BEEF, sc, ra);
    issue(1'b0, 32'h4, 32'h0, 2, 1'b0, 32'hCAFE_1122, sc, ra);
    issue(1'b0, 32'h2, 32'h0, 2, 1'b0, 32'h1122_3344, sc, ra);
    vectors++;
    if (sc !== 2 || ra !== 2) begin
      miscompares++;
      $display("FAIL cross_load_timing: stall_cycles=%0d resp_at=%0d, want 2/2", sc, ra);
    end
  endtask

  task automatic test_cross_half_load();
    int sc, ra;
    issue(1'b1, 32'h4, 32'h8012_3456, 2, 1'b0, 32'h0, sc, ra);
    issue(1'b1, 32'h8, 32'hABCD_EFF0, 2, 1'b0, 32'h0, sc, ra);
    @(posedge clk); #1;
    start(1'b0, 32'h7, 32'h0, 1, 1'b1, 32'hFFFF_F080);
    @(negedge clk);
    sampleResp();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h001 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL half_cross_beat0: en=%b we=%b addr=%h stall=%b, want 1/0/001/1", mem_en, mem_we, mem_addr, stall);
    end
    @(negedge clk);
    sampleResp();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h002 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL half_cross_beat1: en=%b we=%b addr=%h stall=%b, want 1/0/002/1", mem_en, mem_we, mem_addr, stall);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || stall !== 1'b0 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL half_cross_resp: resp_valid=%b stall=%b mem_en=%b, want 1/0/0", resp_valid, stall, mem_en);
    end
    sampleResp();
  endtask

  task automatic test_wrap();
    int sc, ra;
    issue(1'b1, 32'hFFC, 32'h5566_7788, 2, 1'b0, 32'h0, sc, ra);
    issue(1'b1, 32'h000, 32'h99AA_BBCC, 2, 1'b0, 32'h0, sc, ra);
    @(posedge clk); #1;
    start(1'b0, 32'hFFD, 32'h0, 2, 1'b0, 32'hCC55_6677);
    @(negedge clk);
    sampleResp();
    vectors++;
    if (mem_addr !== 10'h3FF || mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_beat0: addr=%h en=%b, want 3ff/1", mem_addr, mem_en);
    end
    @(negedge clk);
    sampleResp();
    vectors++;
    if (mem_addr !== 10'h000 || mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_beat1: addr=%h en=%b, want 000/1", mem_addr, mem_en);
    end
    @(negedge clk);
    sampleResp();
  endtask

  task automatic test_reset_mid_load();
    int sc, ra;
    logic en0;
    logic [ADDR_W-1:0] addr0;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h6, 32'h0, 2, 1'b0);
    @(negedge clk);
    sampleResp();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    sampleResp();
    vectors++;
    if (mem_en !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ld_hi: mem_en=%b stall=%b, want 0/0", mem_en, stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start(1'b0, 32'h4, 32'h0, 2, 1'b0, refLoad(32'h4, 4, 1'b0));
    complete(sc, ra, en0, addr0);
    vectors++;
    if (en0 !== 1'b1 || addr0 !== 10'h001 || ra !== 1) begin
      miscompares++;
      $display("FAIL rst_ld_accept: mem_en=%b addr=%h resp_at=%0d, want 1/001/1", en0, addr0, ra);
    end
  endtask

  task automatic test_reset_mid_store();
    int sc, ra;
    logic en0;
    logic [ADDR_W-1:0] addr0;
    issue(1'b1, 32'h10, 32'h0000_0000, 2, 1'b0, 32'h0, sc, ra);
    issue(1'b1, 32'h14, 32'h0102_0304, 2, 1'b0, 32'h0, sc, ra);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h11, 32'hF00D_FACE, 2, 1'b0);
    @(negedge clk);
    vectors++;
    if (mem_be !== 4'b1110 || mem_wdata !== 32'h0DFA_CE00 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_st_beat0: be=%b wdata=%h stall=%b, want 1110/0dface00/1", mem_be, mem_wdata, stall);
    end
    refStore(32'h11, 32'h000D_FACE, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_st_hi: mem_en=%b stall=%b, want 0/0", mem_en, stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start(1'b0, 32'h14, 32'h0, 2, 1'b0, 32'h0102_0304);
    complete(sc, ra, en0, addr0);
    vectors++;
    if (en0 !== 1'b1 || addr0 !== 10'h005) begin
      miscompares++;
      $display("FAIL rst_st_accept: mem_en=%b addr=%h, want 1/005", en0, addr0);
    end
    issue(1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0DFA_CE00, sc, ra);
  endtask

  task automatic test_back_to_back();
    int sc, ra;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'(4 * i), 32'hA0B0_C000 + 32'(i), 2, 1'b0, 32'h0, sc, ra);
      vectors++;
      if (sc !== 0) begin
        miscompares++;
        $display("FAIL b2b_store_stall: word %0d stall_cycles=%0d, want 0", i, sc);
      end
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'(4 * i), 32'h0, 2, 1'b0, 32'hA0B0_C000 + 32'(i), sc, ra);
      vectors++;
      if (sc !== 1 || ra !== 1) begin
        miscompares++;
        $display("FAIL b2b_load_timing: word %0d stall=%0d resp_at=%0d, want 1/1", i, sc, ra);
      end
    end
  endtask

  task automatic test_random();
    int sc, ra, sz, n, w, expStall;
    logic we, sg;
    logic [31:0] a, wd, e;
    for (int i = 0; i < 8; i++) issue(1'b1, 32'(4 * i), $urandom(), 2, 1'b0, 32'h0, sc, ra);
    for (int i = 1020; i < 1024; i++) issue(1'b1, 32'(4 * i), $urandom(), 2, 1'b0, 32'h0, sc, ra);
    for (int k = 0; k < 80; k++) begin
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 4));
      w  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 27)) : int'($urandom_range(4080, 4095));
      a  = ($urandom() & 32'hFFFF_F000) | 32'(w);
      wd = $urandom();
      n  = szBytes(sz);
      e  = we ? 32'h0 : refLoad(a, n, sg);
      expStall = ((int'(a[1:0]) + n) > 4) ? (we ? 1 : 2) : (we ? 0 : 1);
      issue(we, a, wd, sz, sg, e, sc, ra);
      vectors++;
      if (sc !== expStall || (!we && ra !== expStall)) begin
        miscompares++;
        $display("FAIL rand_timing: we=%b addr=%h n=%0d stall=%0d resp_at=%0d, want stall %0d",
                 we, a, n, sc, ra, expStall);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2, 1'b0);
    test_reset();
    test_byte_store_load();
    test_cross_store();
    test_cross_half_load();
    test_wrap();
    test_reset_mid_load();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    idle(3);
    vectors++;
    if (expQ.size() !== 0) begin
      miscompares++;
      $display("FAIL resp_missing: %0d expected load results never returned", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
